// File: rtl/priority_encoder_16.sv
// Registered 16:4 priority encoder with sticky request capture and a valid/ready handshake.
// Bit 0 has the highest priority. A presented index stays pending until the consumer accepts it.
module priority_encoder_16 #(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_in,
  input  logic [N_REQ-1:0] req_in,
  input  logic             ready_in,
  output logic [IDX_W-1:0] idx_out,
  output logic             valid_out,
  output logic [N_REQ-1:0] pending_out,
  output logic [CNT_W-1:0] pend_cnt_out
);

  logic [N_REQ-1:0] pending_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;

  logic             acc;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] avail;
  logic [N_REQ-1:0] captured;
  logic [N_REQ-1:0] pending_d;
  logic             load_out;
  logic [CNT_W-1:0] cnt;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
    lowest_set = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  always_comb begin
    acc = valid_q & ready_in;
    clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      clr[i] = acc && (idx_q == IDX_W'(i));
    end
    avail     = pending_q & ~clr;
    captured  = en_in ? req_in : '0;
    // New requests are OR-ed in after the clear so a re-request of the accepted bit survives.
    pending_d = avail | captured;
    load_out  = !valid_q || ready_in;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt = cnt + CNT_W'(pending_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // The output stage only sees the pre-edge pending value, hence the two-edge request latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else if (load_out) begin
      valid_q <= |avail;
      idx_q   <= lowest_set(avail);
    end
  end

  assign idx_out      = idx_q;
  assign valid_out    = valid_q;
  assign pending_out  = pending_q;
  assign pend_cnt_out = cnt;

endmodule

// File: tb/tb_priority_encoder_16.sv
// Self-checking bench for priority_encoder_16: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the encoder's documented behaviour.
module tb_priority_encoder_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_in = 1'b0;
  logic [15:0] req_in = '0;
  logic        ready_in = 1'b0;
  logic [3:0]  idx_out;
  logic        valid_out;
  logic [15:0] pending_out;
  logic [4:0]  pend_cnt_out;

  int n_asserts = 0;
  int n_fail = 0;

  bit m_pend[16];
  bit m_valid;
  int m_idx;

  priority_encoder_16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_in        (en_in),
    .req_in       (req_in),
    .ready_in     (ready_in),
    .idx_out      (idx_out),
    .valid_out    (valid_out),
    .pending_out  (pending_out),
    .pend_cnt_out (pend_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
  endtask

  function automatic logic [15:0] modelVector();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int modelCount();
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  task automatic checkOutput(input string tag);
    checkValue({tag, ".pending"}, 32'(pending_out), 32'(modelVector()));
    checkValue({tag, ".count"}, 32'(pend_cnt_out), 32'(modelCount()));
    checkValue({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    checkValue({tag, ".idx"}, 32'(idx_out), 32'(m_idx));
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare just after the edge.
  task automatic applyStimulus(input string tag, input logic en, input logic [15:0] req,
                               input logic rdy);
    bit avail[16];
    bit any;
    int first;
    en_in    = en;
    req_in   = req;
    ready_in = rdy;
    avail = m_pend;
    if (m_valid && rdy) avail[m_idx] = 1'b0;
    any   = 1'b0;
    first = 0;
    for (int i = 0; i < 16; i++) begin
      if (avail[i] && !any) begin
        any   = 1'b1;
        first = i;
      end
    end
    @(posedge clk);
    #1;
    if (!m_valid || rdy) begin
      m_valid = any;
      m_idx   = first;
    end
    for (int i = 0; i < 16; i++) m_pend[i] = avail[i] || (en && req[i]);
    checkOutput(tag);
  endtask

  initial begin
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    $display("[TB] single request");
    applyStimulus("t1.capture", 1'b1, 16'h0001, 1'b1);
    checkValue("t1.pending_after_edge1", 32'(pending_out), 32'h0001);
    applyStimulus("t1.present", 1'b1, 16'h0000, 1'b1);
    checkValue("t1.valid_after_edge2", 32'(valid_out), 32'd1);
    applyStimulus("t1.drain", 1'b1, 16'h0000, 1'b1);
    checkValue("t1.valid_drop", 32'(valid_out), 32'd0);

    $display("[TB] priority sequence");
    applyStimulus("t2.capture", 1'b1, 16'h8421, 1'b1);
    checkValue("t2.count4", 32'(pend_cnt_out), 32'd4);
    for (int i = 0; i < 5; i++) applyStimulus("t2.drain", 1'b1, 16'h0000, 1'b1);
    checkValue("t2.idle", 32'(valid_out), 32'd0);

    $display("[TB] backpressure");
    applyStimulus("t3.capture", 1'b1, 16'h0010, 1'b0);
    applyStimulus("t3.present", 1'b1, 16'h0000, 1'b0);
    applyStimulus("t3.hiprio", 1'b1, 16'h0001, 1'b0);
    applyStimulus("t3.hold", 1'b1, 16'h0000, 1'b0);
    checkValue("t3.held_idx", 32'(idx_out), 32'd4);
    checkValue("t3.held_count", 32'(pend_cnt_out), 32'd2);
    applyStimulus("t3.accept", 1'b1, 16'h0000, 1'b1);
    checkValue("t3.next_idx", 32'(idx_out), 32'd0);
    applyStimulus("t3.drain", 1'b1, 16'h0000, 1'b1);
    applyStimulus("t3.idle", 1'b1, 16'h0000, 1'b1);

    $display("[TB] capture disabled");
    for (int i = 0; i < 5; i++) applyStimulus("t4.disabled", 1'b0, 16'hFFFF, 1'b1);
    checkValue("t4.pending_zero", 32'(pending_out), 32'h0);

    $display("[TB] set wins");
    applyStimulus("t5.capture", 1'b1, 16'h0008, 1'b0);
    applyStimulus("t5.present", 1'b1, 16'h0000, 1'b0);
    applyStimulus("t5.rerequest", 1'b1, 16'h0008, 1'b1);
    checkValue("t5.pending_kept", 32'(pending_out), 32'h0008);
    checkValue("t5.bubble", 32'(valid_out), 32'd0);
    applyStimulus("t5.represent", 1'b1, 16'h0000, 1'b0);
    checkValue("t5.idx_again", 32'(idx_out), 32'd3);
    applyStimulus("t5.accept", 1'b1, 16'h0000, 1'b1);
    applyStimulus("t5.idle", 1'b1, 16'h0000, 1'b1);

    $display("[TB] all ones");
    applyStimulus("ones.capture", 1'b1, 16'hFFFF, 1'b1);
    checkValue("ones.count16", 32'(pend_cnt_out), 32'd16);
    for (int i = 0; i < 18; i++) applyStimulus("ones.drain", 1'b1, 16'h0000, 1'b1);
    checkValue("ones.empty", 32'(pend_cnt_out), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus("t6.capture", 1'b1, 16'h00F0, 1'b0);
    applyStimulus("t6.present", 1'b1, 16'h0000, 1'b0);
    checkValue("t6.pre_idx", 32'(idx_out), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6.async_reset");
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus("t6.quiet", 1'b1, 16'h0000, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 9) < 8),
                    16'($urandom & $urandom & $urandom), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 20; i++) applyStimulus("rand.drain", 1'b0, 16'h0000, 1'b1);
    checkValue("rand.empty", 32'(valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
